// File: rtl/u409_xfer_ack_engine_if.sv
// Bus-side signal bundle for the transfer acknowledge engine.
// Transfer handshake: the master drops nTS for one edge with a one-hot REGION_HIT; the engine answers with a
// single-cycle DSACK (port-size code) or a single-cycle nBERR, holds BUSY until back in IDLE, and ignores nTS meanwhile.
interface u409_xfer_ack_engine_if #(
  parameter int NREG = 4,
  parameter int WS_W = 4
);
  logic                   nTS;
  logic [NREG-1:0]        REGION_HIT;
  logic [NREG*WS_W-1:0]   REGION_WS;
  logic [NREG*2-1:0]      REGION_PORT;
  logic [NREG-1:0]        REGION_EXT;
  logic [NREG-1:0]        EXT_RDY;
  logic [1:0]             DSACK;
  logic                   nBERR;
  logic                   BUSY;
  logic [2:0]             dbg_state;

  modport slave (
    input  nTS, REGION_HIT, REGION_WS, REGION_PORT, REGION_EXT, EXT_RDY,
    output DSACK, nBERR, BUSY, dbg_state
  );

  modport master (
    output nTS, REGION_HIT, REGION_WS, REGION_PORT, REGION_EXT, EXT_RDY,
    input  DSACK, nBERR, BUSY, dbg_state
  );
endinterface

// File: rtl/u409_xfer_ack_engine.sv
// Region-decoded transfer acknowledge engine: wait states, external ready, bus-error timeout.
// All bus outputs are registered from the next-state decode, so nothing combinational reaches the pins.
module u409_xfer_ack_engine #(
  parameter int NREG   = 4,
  parameter int WS_W   = 4,
  parameter int TO_CYC = 255
) (
  input  logic                   CLK40,
  input  logic                   nRESET,
  u409_xfer_ack_engine_if.slave  bus
);

  localparam int IDX_W = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int TO_W  = $clog2(TO_CYC);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAIT    = 3'd1;
  localparam logic [2:0] S_ACK     = 3'd2;
  localparam logic [2:0] S_BERR    = 3'd3;
  localparam logic [2:0] S_RECOVER = 3'd4;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);

  logic [2:0]       r_state;
  logic [IDX_W-1:0] r_idx;
  logic [WS_W-1:0]  r_wcnt;
  logic [TO_W-1:0]  r_tcnt;
  logic [1:0]       r_port;
  logic             r_ext;
  logic [1:0]       r_dsack;
  logic             r_nberr;
  logic             r_busy;

  logic [IDX_W-1:0] w_sel_idx;
  logic [WS_W-1:0]  w_sel_ws;
  logic [1:0]       w_sel_port;
  logic             w_sel_ext;
  logic             w_hit_any;
  logic             w_capture;
  logic             w_ack_now;
  logic [2:0]       w_next;
  logic [WS_W-1:0]  w_wcnt_nxt;
  logic [TO_W-1:0]  w_tcnt_nxt;
  logic [1:0]       w_port_code;

  // Descending scan so the lowest set REGION_HIT bit is the one left selected.
  always_comb begin
    w_sel_idx  = '0;
    w_sel_ws   = '0;
    w_sel_port = '0;
    w_sel_ext  = 1'b0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (bus.REGION_HIT[i]) begin
        w_sel_idx  = IDX_W'(i);
        w_sel_ws   = bus.REGION_WS[i*WS_W +: WS_W];
        w_sel_port = bus.REGION_PORT[i*2 +: 2];
        w_sel_ext  = bus.REGION_EXT[i];
      end
    end
  end

  assign w_hit_any   = |bus.REGION_HIT;
  assign w_capture   = (r_state == S_IDLE) && !bus.nTS && w_hit_any;
  assign w_ack_now   = (r_wcnt == '0) && (!r_ext || bus.EXT_RDY[r_idx]);
  assign w_port_code = (r_port == 2'b11) ? 2'b00 : r_port;

  always_comb begin
    w_next     = r_state;
    w_wcnt_nxt = r_wcnt;
    w_tcnt_nxt = r_tcnt;
    case (r_state)
      S_IDLE: begin
        if (w_capture) begin
          w_next     = S_WAIT;
          w_wcnt_nxt = w_sel_ws;
          w_tcnt_nxt = '0;
        end
      end
      S_WAIT: begin
        if (r_wcnt != '0) w_wcnt_nxt = r_wcnt - 1'b1;
        // An acknowledge on the timeout edge takes precedence over the bus error.
        if (w_ack_now)              w_next = S_ACK;
        else if (r_tcnt == TO_LAST) w_next = S_BERR;
        else                        w_tcnt_nxt = r_tcnt + 1'b1;
      end
      S_ACK:     w_next = S_RECOVER;
      S_BERR:    w_next = S_RECOVER;
      S_RECOVER: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK40 or negedge nRESET) begin
    if (!nRESET) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_wcnt  <= '0;
      r_tcnt  <= '0;
      r_port  <= 2'b00;
      r_ext   <= 1'b0;
      r_dsack <= 2'b11;
      r_nberr <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_wcnt  <= w_wcnt_nxt;
      r_tcnt  <= w_tcnt_nxt;
      if (w_capture) begin
        r_idx  <= w_sel_idx;
        r_port <= w_sel_port;
        r_ext  <= w_sel_ext;
      end
      r_dsack <= (w_next == S_ACK) ? w_port_code : 2'b11;
      r_nberr <= (w_next != S_BERR);
      r_busy  <= (w_next != S_IDLE);
    end
  end

  assign bus.DSACK     = r_dsack;
  assign bus.nBERR     = r_nberr;
  assign bus.BUSY      = r_busy;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_u409_xfer_ack_engine.sv
// Directed bench: two engines share stimulus, one with the default timeout and one with an 8-cycle timeout.
module tb_u409_xfer_ack_engine;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_chk;

  u409_xfer_ack_engine_if #(.NREG(4), .WS_W(4)) ifa ();
  u409_xfer_ack_engine_if #(.NREG(4), .WS_W(4)) ifb ();

  assign ifb.nTS         = ifa.nTS;
  assign ifb.REGION_HIT  = ifa.REGION_HIT;
  assign ifb.REGION_WS   = ifa.REGION_WS;
  assign ifb.REGION_PORT = ifa.REGION_PORT;
  assign ifb.REGION_EXT  = ifa.REGION_EXT;
  assign ifb.EXT_RDY     = ifa.EXT_RDY;

  u409_xfer_ack_engine #(.NREG(4), .WS_W(4), .TO_CYC(255)) dut_a (
    .CLK40 (clk),
    .nRESET(rst_n),
    .bus   (ifa)
  );

  u409_xfer_ack_engine #(.NREG(4), .WS_W(4), .TO_CYC(8)) dut_b (
    .CLK40 (clk),
    .nRESET(rst_n),
    .bus   (ifb)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Region map: r0 WS0 32-bit, r1 WS0 8-bit ext, r2 WS3 16-bit, r3 WS5 32-bit.
  task automatic set_defaults();
    ifa.nTS         = 1'b1;
    ifa.REGION_HIT  = 4'b0000;
    ifa.REGION_WS   = 16'h5300;
    ifa.REGION_PORT = 8'h18;
    ifa.REGION_EXT  = 4'b0010;
    ifa.EXT_RDY     = 4'b0000;
  endtask

  initial begin
    n_pass = 0;
    n_chk  = 0;
    rst_n  = 1'b0;
    set_defaults();

    #12;
    chk("rst_dsack_a", {2'b0, ifa.DSACK}, 4'h3);
    chk("rst_nberr_a", {3'b0, ifa.nBERR}, 4'h1);
    chk("rst_busy_a",  {3'b0, ifa.BUSY},  4'h0);
    chk("rst_dsack_b", {2'b0, ifb.DSACK}, 4'h3);
    chk("rst_busy_b",  {3'b0, ifb.BUSY},  4'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick();

    // Region 0, no wait states, 32-bit port
    ifa.nTS = 1'b0; ifa.REGION_HIT = 4'b0001;
    tick();
    chk("t1_busy_N",   {3'b0, ifa.BUSY}, 4'h1);
    chk("t1_dsack_N",  {2'b0, ifa.DSACK}, 4'h3);
    ifa.nTS = 1'b1; ifa.REGION_HIT = 4'b0000;
    tick();
    chk("t1_dsack_N1", {2'b0, ifa.DSACK}, 4'h0);
    chk("t1_busy_N1",  {3'b0, ifa.BUSY}, 4'h1);
    tick();
    chk("t1_dsack_N2", {2'b0, ifa.DSACK}, 4'h3);
    chk("t1_busy_N2",  {3'b0, ifa.BUSY}, 4'h1);
    tick();
    chk("t1_busy_N3",  {3'b0, ifa.BUSY}, 4'h0);

    // Region 2, WS=3, 16-bit; WS input changed after capture must not matter
    ifa.nTS = 1'b0; ifa.REGION_HIT = 4'b0100;
    tick();
    ifa.nTS = 1'b1; ifa.REGION_HIT = 4'b0000; ifa.REGION_WS = 16'h5000;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("t2_dsack_wait", {2'b0, ifa.DSACK}, 4'h3);
    end
    tick();
    chk("t2_dsack_N4", {2'b0, ifa.DSACK}, 4'h1);
    tick();
    chk("t2_dsack_N5", {2'b0, ifa.DSACK}, 4'h3);
    chk("t2_busy_N5",  {3'b0, ifa.BUSY}, 4'h1);
    tick();
    chk("t2_busy_N6",  {3'b0, ifa.BUSY}, 4'h0);
    ifa.REGION_WS = 16'h5300;

    // Region 1, external ready held off for 10 cycles (default timeout engine)
    ifa.nTS = 1'b0; ifa.REGION_HIT = 4'b0010; ifa.EXT_RDY = 4'b0000;
    tick();
    ifa.nTS = 1'b1; ifa.REGION_HIT = 4'b0000;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("t3_dsack_hold", {2'b0, ifa.DSACK}, 4'h3);
      chk("t3_nberr_hold", {3'b0, ifa.nBERR}, 4'h1);
    end
    ifa.EXT_RDY = 4'b0010;
    tick();
    chk("t3_dsack_ack", {2'b0, ifa.DSACK}, 4'h2);
    chk("t3_nberr_ack", {3'b0, ifa.nBERR}, 4'h1);
    ifa.EXT_RDY = 4'b0000;
    tick();
    chk("t3_dsack_after", {2'b0, ifa.DSACK}, 4'h3);
    tick();
    chk("t3_busy_idle", {3'b0, ifa.BUSY}, 4'h0);
    chk("t3_b_idle",    {3'b0, ifb.BUSY}, 4'h0);

    // Timeout on the 8-cycle engine
    ifa.nTS = 1'b0; ifa.REGION_HIT = 4'b0010;
    tick();
    ifa.nTS = 1'b1; ifa.REGION_HIT = 4'b0000;
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk("t4_nberr_pre", {3'b0, ifb.nBERR}, 4'h1);
    end
    tick();
    chk("t4_nberr_N8", {3'b0, ifb.nBERR}, 4'h0);
    chk("t4_dsack_N8", {2'b0, ifb.DSACK}, 4'h3);
    chk("t4_busy_N8",  {3'b0, ifb.BUSY},  4'h1);
    tick();
    chk("t4_nberr_N9", {3'b0, ifb.nBERR}, 4'h1);
    chk("t4_dsack_N9", {2'b0, ifb.DSACK}, 4'h3);
    tick();
    chk("t4_busy_N10", {3'b0, ifb.BUSY}, 4'h0);
    chk("t4_a_still",  {3'b0, ifa.BUSY}, 4'h1);
    ifa.EXT_RDY = 4'b0010;
    tick();
    chk("t4_a_dsack", {2'b0, ifa.DSACK}, 4'h2);
    ifa.EXT_RDY = 4'b0000;
    tick();
    tick();
    chk("t4_a_idle", {3'b0, ifa.BUSY}, 4'h0);

    // Ready arrives on the timeout edge: acknowledge wins
    ifa.nTS = 1'b0; ifa.REGION_HIT = 4'b0010;
    tick();
    ifa.nTS = 1'b1; ifa.REGION_HIT = 4'b0000;
    for (int i = 1; i <= 7; i++) tick();
    ifa.EXT_RDY = 4'b0010;
    tick();
    chk("t5_b_dsack", {2'b0, ifb.DSACK}, 4'h2);
    chk("t5_b_nberr", {3'b0, ifb.nBERR}, 4'h1);
    ifa.EXT_RDY = 4'b0000;
    tick();
    chk("t5_b_nberr_N9", {3'b0, ifb.nBERR}, 4'h1);
    chk("t5_b_dsack_N9", {2'b0, ifb.DSACK}, 4'h3);
    tick();
    chk("t5_b_idle", {3'b0, ifb.BUSY}, 4'h0);

    // Multiple hits pick the lowest region; no hit leaves the bus unclaimed
    ifa.nTS = 1'b0; ifa.REGION_HIT = 4'b0110; ifa.EXT_RDY = 4'b0010;
    tick();
    ifa.nTS = 1'b1; ifa.REGION_HIT = 4'b0000;
    tick();
    chk("t6_dsack_r1", {2'b0, ifa.DSACK}, 4'h2);
    ifa.EXT_RDY = 4'b0000;
    tick();
    tick();
    chk("t6_idle", {3'b0, ifa.BUSY}, 4'h0);
    ifa.nTS = 1'b0; ifa.REGION_HIT = 4'b0000;
    tick();
    chk("t6_nohit_busy",  {3'b0, ifa.BUSY},  4'h0);
    chk("t6_nohit_dsack", {2'b0, ifa.DSACK}, 4'h3);
    tick();
    chk("t6_nohit_busy2", {3'b0, ifa.BUSY},  4'h0);
    ifa.nTS = 1'b1;
    tick();

    // Reset in the middle of a WS=5 wait
    ifa.nTS = 1'b0; ifa.REGION_HIT = 4'b1000;
    tick();
    chk("t7_busy_N", {3'b0, ifa.BUSY}, 4'h1);
    ifa.nTS = 1'b1; ifa.REGION_HIT = 4'b0000;
    tick();
    tick();
    chk("t7_busy_mid", {3'b0, ifa.BUSY}, 4'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_rst_busy",  {3'b0, ifa.BUSY},  4'h0);
    chk("t7_rst_dsack", {2'b0, ifa.DSACK}, 4'h3);
    chk("t7_rst_nberr", {3'b0, ifa.nBERR}, 4'h1);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t7_no_dsack", {2'b0, ifa.DSACK}, 4'h3);
    end
    ifa.nTS = 1'b0; ifa.REGION_HIT = 4'b0001;
    tick();
    chk("t7_new_busy", {3'b0, ifa.BUSY}, 4'h1);
    ifa.nTS = 1'b1; ifa.REGION_HIT = 4'b0000;
    tick();
    chk("t7_new_dsack", {2'b0, ifa.DSACK}, 4'h0);
    tick();
    chk("t7_new_dsack2", {2'b0, ifa.DSACK}, 4'h3);
    tick();
    chk("t7_new_idle", {3'b0, ifa.BUSY}, 4'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
